// File: rtl/xover_iir_mc.sv
// Multi-channel LR crossover: N_SECT cascaded DF-I biquads per band, one shared multiplier.
// Optional feature: define XOVER_IIR_SAT_EN to clamp every section result to int32.
module xover_iir_mc #(
  parameter int N_CH   = 2,
  parameter int N_SECT = 2,
  parameter int COEF_W = 26,
  parameter int ACC_W  = COEF_W + 34
) (
  input  logic                i_mck,
  input  logic                i_rst,
  input  logic [32*N_CH-1:0]  i_iir,
  input  logic                i_sample_valid,
  input  logic [COEF_W-1:0]   i_lp_a0,
  input  logic [COEF_W-1:0]   i_lp_a1,
  input  logic [COEF_W-1:0]   i_lp_a2,
  input  logic [COEF_W-1:0]   i_lp_b1,
  input  logic [COEF_W-1:0]   i_lp_b2,
  input  logic [COEF_W-1:0]   i_hp_a0,
  input  logic [COEF_W-1:0]   i_hp_a1,
  input  logic [COEF_W-1:0]   i_hp_a2,
  input  logic [COEF_W-1:0]   i_hp_b1,
  input  logic [COEF_W-1:0]   i_hp_b2,
  output logic [32*N_CH-1:0]  o_iir_lpf,
  output logic [32*N_CH-1:0]  o_iir_hpf,
  output logic                o_sample_valid,
  output logic                o_busy,
  output logic                o_overrun
);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SECT_W = (N_SECT > 1) ? $clog2(N_SECT) : 1;
  localparam int PROD_W = COEF_W + 32;
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(N_CH - 1);
  localparam logic [SECT_W-1:0] LAST_SECT = SECT_W'(N_SECT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic                   band_q, band_d;   // 0 = HPF, 1 = LPF
  logic [SECT_W-1:0]      sect_q, sect_d;
  logic [2:0]             step_q, step_d;
  logic                   ovr_q, ovr_d;

  logic [N_CH-1:0][31:0]  in_q, in_d;
  logic [N_CH-1:0][31:0]  zx1_q, zx1_d, zx2_q, zx2_d;
  logic [N_CH-1:0][1:0][N_SECT-1:0][31:0] y1_q, y1_d, y2_q, y2_d;
  logic [N_CH-1:0][31:0]  hpf_q, hpf_d, lpf_q, lpf_d;

  // Output of the previous section plus its pre-update y1/y2: next section's x, x1, x2.
  logic [31:0]            chain_q, chain_d, px1_q, px1_d, px2_q, px2_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  logic [COEF_W-1:0]      c_a0, c_a1, c_a2, c_b1, c_b2;
  logic [31:0]            sx, sx1, sx2, sy1, sy2;
  logic signed [31:0]     mul_x;
  logic signed [COEF_W-1:0] mul_c;
  logic signed [ACC_W-1:0]  pe, acc_sh;
  logic [31:0]            res;

  assign c_a0 = band_q ? i_lp_a0 : i_hp_a0;
  assign c_a1 = band_q ? i_lp_a1 : i_hp_a1;
  assign c_a2 = band_q ? i_lp_a2 : i_hp_a2;
  assign c_b1 = band_q ? i_lp_b1 : i_hp_b1;
  assign c_b2 = band_q ? i_lp_b2 : i_hp_b2;

  assign sy1 = y1_q[ch_q][band_q][sect_q];
  assign sy2 = y2_q[ch_q][band_q][sect_q];
  assign sx  = (sect_q == '0) ? in_q[ch_q]  : chain_q;
  assign sx1 = (sect_q == '0) ? zx1_q[ch_q] : px1_q;
  assign sx2 = (sect_q == '0) ? zx2_q[ch_q] : px2_q;

  always_comb begin
    mul_x = '0;
    mul_c = '0;
    case (step_q)
      3'd0: begin mul_x = sx;  mul_c = c_a0; end
      3'd1: begin mul_x = sx1; mul_c = c_a1; end
      3'd2: begin mul_x = sx2; mul_c = c_a2; end
      3'd3: begin mul_x = sy1; mul_c = c_b1; end
      3'd4: begin mul_x = sy2; mul_c = c_b2; end
      default: ;
    endcase
  end

  assign prod_d = PROD_W'(mul_x) * PROD_W'(mul_c);
  assign pe     = ACC_W'(prod_q);
  assign acc_sh = acc_q >>> (COEF_W - 2);

`ifdef XOVER_IIR_SAT_EN
  always_comb begin
    if ((&acc_sh[ACC_W-1:31]) || !(|acc_sh[ACC_W-1:31])) res = acc_sh[31:0];
    else res = acc_sh[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end
`else
  logic unused_sh;
  assign unused_sh = ^acc_sh[ACC_W-2:31];
  assign res = {acc_sh[ACC_W-1], acc_sh[30:0]};
`endif

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    band_d  = band_q;
    sect_d  = sect_q;
    step_d  = step_q;
    ovr_d   = ovr_q;
    in_d    = in_q;
    zx1_d   = zx1_q;
    zx2_d   = zx2_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    hpf_d   = hpf_q;
    lpf_d   = lpf_q;
    chain_d = chain_q;
    px1_d   = px1_q;
    px2_d   = px2_q;
    acc_d   = acc_q;

    if (i_sample_valid && state_q == RUN) ovr_d = 1'b1;

    case (state_q)
      // DONE accepts too, so back-to-back samples run at the L+1 period.
      IDLE, DONE: begin
        state_d = IDLE;
        if (i_sample_valid) begin
          state_d = RUN;
          in_d    = i_iir;
          ch_d    = '0;
          band_d  = 1'b0;
          sect_d  = '0;
          step_d  = '0;
        end
      end
      RUN: begin
        step_d = step_q + 3'd1;
        case (step_q)
          3'd1:       acc_d = pe;
          3'd2, 3'd3: acc_d = acc_q + pe;
          3'd4, 3'd5: acc_d = acc_q - pe;
          3'd6: begin
            step_d = '0;
            y2_d[ch_q][band_q][sect_q] = sy1;
            y1_d[ch_q][band_q][sect_q] = res;
            px1_d   = sy1;
            px2_d   = sy2;
            chain_d = res;
            if (sect_q != LAST_SECT) begin
              sect_d = sect_q + SECT_W'(1);
            end else if (!band_q) begin
              hpf_d[ch_q] = res;
              band_d      = 1'b1;
              sect_d      = '0;
            end else begin
              lpf_d[ch_q] = res;
              zx2_d[ch_q] = zx1_q[ch_q];
              zx1_d[ch_q] = in_q[ch_q];
              band_d      = 1'b0;
              sect_d      = '0;
              if (ch_q == LAST_CH) state_d = DONE;
              else ch_d = ch_q + CH_W'(1);
            end
          end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_mck) begin
    if (i_rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      band_q  <= 1'b0;
      sect_q  <= '0;
      step_q  <= '0;
      ovr_q   <= 1'b0;
      in_q    <= '0;
      zx1_q   <= '0;
      zx2_q   <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      hpf_q   <= '0;
      lpf_q   <= '0;
      chain_q <= '0;
      px1_q   <= '0;
      px2_q   <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      band_q  <= band_d;
      sect_q  <= sect_d;
      step_q  <= step_d;
      ovr_q   <= ovr_d;
      in_q    <= in_d;
      zx1_q   <= zx1_d;
      zx2_q   <= zx2_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      hpf_q   <= hpf_d;
      lpf_q   <= lpf_d;
      chain_q <= chain_d;
      px1_q   <= px1_d;
      px2_q   <= px2_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
    end
  end

  assign o_iir_hpf      = hpf_q;
  assign o_iir_lpf      = lpf_q;
  assign o_sample_valid = (state_q == DONE);
  assign o_busy         = (state_q != IDLE);
  assign o_overrun      = ovr_q;
endmodule

// File: tb/tb_xover_iir_mc.sv
// Randomized bench for xover_iir_mc with a sample-level cascade reference model.
// Honors XOVER_IIR_SAT_EN the same way the design does.
module tb_xover_iir_mc;
  localparam int L  = 14 * 2 * 2;  // default DUT: 2 sections, 2 channels
  localparam int L2 = 14 * 1 * 2;  // delay-path DUT: 1 section, 2 channels

  logic i_mck = 1'b0;
  logic i_rst = 1'b1;
  logic [63:0] iir = '0;
  logic sv = 1'b0, sv2 = 1'b0;
  logic [25:0] lp_a0 = '0, lp_a1 = '0, lp_a2 = '0, lp_b1 = '0, lp_b2 = '0;
  logic [25:0] hp_a0 = '0, hp_a1 = '0, hp_a2 = '0, hp_b1 = '0, hp_b2 = '0;
  logic [63:0] lpf, hpf, lpf2, hpf2;
  logic osv, busy, ovr, osv2, busy2, ovr2;
  int checks = 0, errors = 0;

  always #5 i_mck = ~i_mck;

  xover_iir_mc u_dut (
    .i_mck(i_mck), .i_rst(i_rst), .i_iir(iir), .i_sample_valid(sv),
    .i_lp_a0(lp_a0), .i_lp_a1(lp_a1), .i_lp_a2(lp_a2), .i_lp_b1(lp_b1), .i_lp_b2(lp_b2),
    .i_hp_a0(hp_a0), .i_hp_a1(hp_a1), .i_hp_a2(hp_a2), .i_hp_b1(hp_b1), .i_hp_b2(hp_b2),
    .o_iir_lpf(lpf), .o_iir_hpf(hpf), .o_sample_valid(osv), .o_busy(busy), .o_overrun(ovr));

  xover_iir_mc #(.N_CH(2), .N_SECT(1)) u_dly (
    .i_mck(i_mck), .i_rst(i_rst), .i_iir(iir), .i_sample_valid(sv2),
    .i_lp_a0(lp_a0), .i_lp_a1(lp_a1), .i_lp_a2(lp_a2), .i_lp_b1(lp_b1), .i_lp_b2(lp_b2),
    .i_hp_a0(hp_a0), .i_hp_a1(hp_a1), .i_hp_a2(hp_a2), .i_hp_b1(hp_b1), .i_hp_b2(hp_b2),
    .o_iir_lpf(lpf2), .o_iir_hpf(hpf2), .o_sample_valid(osv2), .o_busy(busy2), .o_overrun(ovr2));

  // Reference: each section keeps its own input and output history, [ch][band][sect].
  logic [31:0] mx1 [2][2][2], mx2 [2][2][2], my1 [2][2][2], my2 [2][2][2];
  logic [31:0] exp_hp [2], exp_lp [2];

  function automatic longint s64(input logic [31:0] v); return longint'($signed(v)); endfunction
  function automatic longint c64(input logic [25:0] v); return longint'($signed(v)); endfunction

  function automatic logic [31:0] red(input longint acc);
    longint sh;
    sh = acc >>> 24;
`ifdef XOVER_IIR_SAT_EN
    if (sh > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (sh < -64'sd2147483648) return 32'h8000_0000;
    return sh[31:0];
`else
    return {sh[63], sh[30:0]};
`endif
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) for (int b = 0; b < 2; b++) for (int s = 0; s < 2; s++) begin
      mx1[c][b][s] = '0; mx2[c][b][s] = '0; my1[c][b][s] = '0; my2[c][b][s] = '0;
    end
  endtask

  task automatic model_sample(input logic [63:0] d);
    for (int c = 0; c < 2; c++) for (int b = 0; b < 2; b++) begin
      logic [31:0] v, r;
      longint acc;
      v = d[32*c +: 32];
      for (int s = 0; s < 2; s++) begin
        acc = c64(b ? lp_a0 : hp_a0) * s64(v)
            + c64(b ? lp_a1 : hp_a1) * s64(mx1[c][b][s])
            + c64(b ? lp_a2 : hp_a2) * s64(mx2[c][b][s])
            - c64(b ? lp_b1 : hp_b1) * s64(my1[c][b][s])
            - c64(b ? lp_b2 : hp_b2) * s64(my2[c][b][s]);
        r = red(acc);
        mx2[c][b][s] = mx1[c][b][s]; mx1[c][b][s] = v;
        my2[c][b][s] = my1[c][b][s]; my1[c][b][s] = r;
        v = r;
      end
      if (b == 0) exp_hp[c] = v; else exp_lp[c] = v;
    end
  endtask

  task automatic set_coefs(input logic [25:0] ha0, ha1, ha2, hb1, hb2,
                           input logic [25:0] la0, la1, la2, lb1, lb2);
    hp_a0 = ha0; hp_a1 = ha1; hp_a2 = ha2; hp_b1 = hb1; hp_b2 = hb2;
    lp_a0 = la0; lp_a1 = la1; lp_a2 = la2; lp_b1 = lb1; lp_b2 = lb2;
  endtask

  task automatic rand_coefs();
    set_coefs(26'($urandom), 26'($urandom), 26'($urandom), 26'($urandom), 26'($urandom),
              26'($urandom), 26'($urandom), 26'($urandom), 26'($urandom), 26'($urandom));
  endtask

  // Accept one sample at edge k and watch a bounded window; j indexes the cycle after edge k+j.
  task automatic run_sample(input bit sel2, input logic [63:0] d, input int extra_at,
                            input int rst_at, output int lat, output int nval, output int berr);
    int ll;
    ll = sel2 ? L2 : L;
    @(negedge i_mck);
    iir = d;
    if (sel2) sv2 = 1'b1; else sv = 1'b1;
    @(posedge i_mck);
    lat = -1; nval = 0; berr = 0;
    for (int j = 0; j <= ll + 4; j++) begin
      @(negedge i_mck);
      sv2   = 1'b0;
      sv    = (j + 1 == extra_at);
      i_rst = (j + 1 == rst_at);
      if (sel2 ? osv2 : osv) begin nval++; if (lat < 0) lat = j; end
      if (j <= ll && !(sel2 ? busy2 : busy)) berr++;
      if (j == ll + 1 && (sel2 ? busy2 : busy)) berr++;
    end
    sv = 1'b0; i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; sv = 1'b0; sv2 = 1'b0;
    repeat (2) @(negedge i_mck);
    i_rst = 1'b0;
    @(negedge i_mck);
    checks++; if (hpf !== 64'd0) begin errors++; $display("FAIL reset_hpf got %h exp 0", hpf); end
    checks++; if (lpf !== 64'd0) begin errors++; $display("FAIL reset_lpf got %h exp 0", lpf); end
    checks++; if ({busy, ovr, osv} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, ovr, osv}); end
    checks++; if ({lpf2, busy2, ovr2, osv2} !== 67'd0) begin errors++; $display("FAIL reset_dly got %h exp 0", {lpf2, busy2, ovr2, osv2}); end
    model_reset();
  endtask

  task automatic test_unity();
    logic [63:0] d;
    int lat, nv, be;
    d = {32'hFFFF_EC78, 32'd1000};  // ch1 = -5000, ch0 = 1000
    set_coefs(26'h100_0000, 0, 0, 0, 0, 26'h100_0000, 0, 0, 0, 0);
    run_sample(1'b0, d, -1, -1, lat, nv, be);
    model_sample(d);
    checks++; if (lat !== L) begin errors++; $display("FAIL unity_latency got %0d exp %0d", lat, L); end
    checks++; if (nv !== 1) begin errors++; $display("FAIL unity_valid_count got %0d exp 1", nv); end
    checks++; if (be !== 0) begin errors++; $display("FAIL unity_busy got %0d bad cycles exp 0", be); end
    checks++; if (hpf !== d) begin errors++; $display("FAIL unity_hpf got %h exp %h", hpf, d); end
    checks++; if (lpf !== d) begin errors++; $display("FAIL unity_lpf got %h exp %h", lpf, d); end
  endtask

  task automatic test_delay_path();
    logic [31:0] expv [3];
    int lat, nv, be;
    expv[0] = 32'd0; expv[1] = 32'd4096; expv[2] = 32'd0;
    set_coefs(0, 0, 0, 0, 0, 0, 26'h100_0000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run_sample(1'b1, (i == 0) ? 64'd4096 : 64'd0, -1, -1, lat, nv, be);
      checks++; if (lpf2[31:0] !== expv[i]) begin errors++; $display("FAIL delay_ch0_%0d got %0d exp %0d", i, lpf2[31:0], expv[i]); end
      checks++; if (lpf2[63:32] !== 32'd0) begin errors++; $display("FAIL delay_ch1_%0d got %0d exp 0", i, lpf2[63:32]); end
      checks++; if (lat !== L2 || nv !== 1) begin errors++; $display("FAIL delay_valid_%0d got lat %0d n %0d exp %0d 1", i, lat, nv, L2); end
    end
  endtask

  task automatic test_random();
    logic [63:0] d;
    int lat, nv, be;
    for (int i = 0; i < 6; i++) begin
      rand_coefs();
      d = {$urandom, $urandom};
      run_sample(1'b0, d, -1, -1, lat, nv, be);
      model_sample(d);
      for (int c = 0; c < 2; c++) begin
        checks++; if (hpf[32*c +: 32] !== exp_hp[c]) begin errors++; $display("FAIL random_hpf_%0d_ch%0d got %h exp %h", i, c, hpf[32*c +: 32], exp_hp[c]); end
        checks++; if (lpf[32*c +: 32] !== exp_lp[c]) begin errors++; $display("FAIL random_lpf_%0d_ch%0d got %h exp %h", i, c, lpf[32*c +: 32], exp_lp[c]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] da, db;
    logic [31:0] ea_h [2], ea_l [2];
    int v1, v2;
    rand_coefs();
    da = {$urandom, $urandom};
    db = {$urandom, $urandom};
    model_sample(da);
    ea_h = exp_hp; ea_l = exp_lp;
    model_sample(db);
    @(negedge i_mck); iir = da; sv = 1'b1;
    @(posedge i_mck);
    v1 = -1; v2 = -1;
    for (int j = 0; j <= 2 * L + 6; j++) begin
      @(negedge i_mck);
      sv = 1'b0;
      if (osv) begin if (v1 < 0) v1 = j; else if (v2 < 0) v2 = j; end
      if (j == L) begin
        for (int c = 0; c < 2; c++) begin
          checks++; if ({hpf[32*c +: 32], lpf[32*c +: 32]} !== {ea_h[c], ea_l[c]}) begin errors++; $display("FAIL b2b_first_ch%0d got %h exp %h", c, {hpf[32*c +: 32], lpf[32*c +: 32]}, {ea_h[c], ea_l[c]}); end
        end
        iir = db; sv = 1'b1;
      end
    end
    checks++; if (v1 !== L || v2 !== 2 * L + 1) begin errors++; $display("FAIL b2b_timing got %0d %0d exp %0d %0d", v1, v2, L, 2 * L + 1); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", ovr); end
    checks++; if ({hpf, lpf} !== {exp_hp[1], exp_hp[0], exp_lp[1], exp_lp[0]}) begin errors++; $display("FAIL b2b_second got %h exp %h", {hpf, lpf}, {exp_hp[1], exp_hp[0], exp_lp[1], exp_lp[0]}); end
  endtask

  task automatic test_overrun();
    logic [63:0] d;
    int lat, nv, be;
    rand_coefs();
    d = {$urandom, $urandom};
    run_sample(1'b0, d, 5, -1, lat, nv, be);
    model_sample(d);
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b exp 1", ovr); end
    checks++; if (nv !== 1 || lat !== L) begin errors++; $display("FAIL overrun_valid got n %0d lat %0d exp 1 %0d", nv, lat, L); end
    checks++; if ({hpf, lpf} !== {exp_hp[1], exp_hp[0], exp_lp[1], exp_lp[0]}) begin errors++; $display("FAIL overrun_data got %h exp %h", {hpf, lpf}, {exp_hp[1], exp_hp[0], exp_lp[1], exp_lp[0]}); end
    d = {$urandom, $urandom};
    run_sample(1'b0, d, -1, -1, lat, nv, be);
    model_sample(d);
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b exp 1", ovr); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    int lat, nv, be;
    rand_coefs();
    d = {$urandom, $urandom};
    run_sample(1'b0, d, -1, 10, lat, nv, be);
    model_reset();
    checks++; if (nv !== 0) begin errors++; $display("FAIL rstmid_valid got %0d exp 0", nv); end
    checks++; if ({hpf, lpf, busy, ovr} !== 130'd0) begin errors++; $display("FAIL rstmid_state got %h exp 0", {hpf, lpf, busy, ovr}); end
    set_coefs(26'h100_0000, 0, 0, 0, 0, 26'h100_0000, 0, 0, 0, 0);
    d = {$urandom, $urandom};
    run_sample(1'b0, d, -1, -1, lat, nv, be);
    model_sample(d);
    checks++; if ({hpf, lpf} !== {d, d}) begin errors++; $display("FAIL rstmid_unity got %h exp %h", {hpf, lpf}, {d, d}); end
    rand_coefs();
    d = {$urandom, $urandom};
    run_sample(1'b0, d, -1, -1, lat, nv, be);
    model_sample(d);
    checks++; if ({hpf, lpf} !== {exp_hp[1], exp_hp[0], exp_lp[1], exp_lp[0]}) begin errors++; $display("FAIL rstmid_history got %h exp %h", {hpf, lpf}, {exp_hp[1], exp_hp[0], exp_lp[1], exp_lp[0]}); end
  endtask

  task automatic test_overflow();
    logic [63:0] d;
    int lat, nv, be;
    set_coefs(26'h1FF_FFFF, 0, 0, 0, 0, 26'h100_0000, 0, 0, 0, 0);
    d = {$urandom, 32'h7FFF_FF00};
    run_sample(1'b0, d, -1, -1, lat, nv, be);
    model_sample(d);
    checks++; if (hpf[31:0] !== exp_hp[0]) begin errors++; $display("FAIL overflow_model got %h exp %h", hpf[31:0], exp_hp[0]); end
`ifdef XOVER_IIR_SAT_EN
    checks++; if (hpf[31:0] !== 32'h7FFF_FFFF) begin errors++; $display("FAIL overflow_sat got %h exp 7fffffff", hpf[31:0]); end
`endif
    checks++; if (lpf[31:0] !== 32'h7FFF_FF00) begin errors++; $display("FAIL overflow_lpf got %h exp 7fffff00", lpf[31:0]); end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_delay_path();
    test_random();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
